// File: rtl/ar_srl_fifo_lvl_if.sv
// rtl/ar_srl_fifo_lvl_if.sv - handshake and level-status bundle for ar_srl_fifo_lvl
interface ar_srl_fifo_lvl_if #(
  parameter int width   = 128,
  parameter int l2depth = 5
);
  logic               ENQ;
  logic [width-1:0]   D_IN;
  logic               DEQ;
  logic [width-1:0]   D_OUT;
  logic               FULL_N;
  logic               EMPTY_N;
  logic [l2depth:0]   COUNT;
  logic               ALMOST_FULL;
  logic               ALMOST_EMPTY;
  logic [l2depth:0]   HWM;
  logic               ERR_OVF;
  logic               ERR_UNF;

  modport master (
    output ENQ, D_IN, DEQ,
    input  D_OUT, FULL_N, EMPTY_N, COUNT, ALMOST_FULL, ALMOST_EMPTY, HWM, ERR_OVF, ERR_UNF
  );

  modport slave (
    input  ENQ, D_IN, DEQ,
    output D_OUT, FULL_N, EMPTY_N, COUNT, ALMOST_FULL, ALMOST_EMPTY, HWM, ERR_OVF, ERR_UNF
  );
endinterface

// File: rtl/ar_srl_fifo_lvl.sv
// rtl/ar_srl_fifo_lvl.sv - SRL FIFO with occupancy, almost flags, sticky errors and high-water mark
module ar_srl_fifo_lvl #(
  parameter int width     = 128,
  parameter int l2depth   = 5,
  parameter int depth     = 2**l2depth,
  parameter int af_thresh = depth - 4,
  parameter int ae_thresh = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CLR,
  ar_srl_fifo_lvl_if.slave      fifo
);
  localparam int cw = l2depth + 1;
  localparam logic [cw-1:0] depth_c = cw'(depth);
  localparam logic [cw-1:0] af_c    = cw'(af_thresh);
  localparam logic [cw-1:0] ae_c    = cw'(ae_thresh);

  logic [width-1:0]   dat [depth];
  logic [cw-1:0]      count;
  logic [cw-1:0]      count_nxt;
  logic [cw-1:0]      hwm;
  logic [l2depth-1:0] head_idx;
  logic               deq_ok;
  logic               enq_ok;
  logic               full_n_r;
  logic               empty_n_r;
  logic               af_r;
  logic               ae_r;
  logic               err_ovf_r;
  logic               err_unf_r;

  // A full FIFO still accepts ENQ when a DEQ frees a slot in the same cycle.
  assign deq_ok    = fifo.DEQ & (count != '0);
  assign enq_ok    = fifo.ENQ & ((count != depth_c) | deq_ok);
  assign count_nxt = count + cw'(enq_ok) - cw'(deq_ok);
  assign head_idx  = l2depth'(count - cw'(1));

  // No reset on the array so it maps onto shift-register primitives.
  always_ff @(posedge CLK) begin
    if (enq_ok) begin
      for (int i = depth - 1; i > 0; i--) begin
        dat[i] <= dat[i-1];
      end
      dat[0] <= fifo.D_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count     <= '0;
      hwm       <= '0;
      full_n_r  <= 1'b1;
      empty_n_r <= 1'b0;
      af_r      <= 1'b0;
      ae_r      <= 1'b1;
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else if (CLR) begin
      count     <= '0;
      hwm       <= '0;
      full_n_r  <= 1'b1;
      empty_n_r <= 1'b0;
      af_r      <= 1'b0;
      ae_r      <= 1'b1;
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else begin
      count     <= count_nxt;
      hwm       <= (count_nxt > hwm) ? count_nxt : hwm;
      full_n_r  <= (count_nxt != depth_c);
      empty_n_r <= (count_nxt != '0);
      af_r      <= (count_nxt >= af_c);
      ae_r      <= (count_nxt <= ae_c);
      err_ovf_r <= err_ovf_r | (fifo.ENQ & ~enq_ok);
      err_unf_r <= err_unf_r | (fifo.DEQ & (count == '0));
    end
  end

  assign fifo.D_OUT        = dat[head_idx];
  assign fifo.COUNT        = count;
  assign fifo.HWM          = hwm;
  assign fifo.FULL_N       = full_n_r;
  assign fifo.EMPTY_N      = empty_n_r;
  assign fifo.ALMOST_FULL  = af_r;
  assign fifo.ALMOST_EMPTY = ae_r;
  assign fifo.ERR_OVF      = err_ovf_r;
  assign fifo.ERR_UNF      = err_unf_r;
endmodule

// File: tb/tb_ar_srl_fifo_lvl.sv
// tb/tb_ar_srl_fifo_lvl.sv - directed checks for ar_srl_fifo_lvl
module tb_ar_srl_fifo_lvl;
  localparam int W = 128;
  localparam int L2 = 5;

  logic CLK = 1'b0;
  logic RST_N;
  logic CLR;
  int   checks = 0;
  int   failures = 0;

  ar_srl_fifo_lvl_if #(.width(W), .l2depth(L2)) bus ();

  ar_srl_fifo_lvl #(.width(W), .l2depth(L2)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CLR   (CLR),
    .fifo  (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         clr, enq, deq;
    logic [W-1:0] din;
    logic [5:0]   count;
    logic         full_n, empty_n, af, ae;
    logic [5:0]   hwm;
    logic         ovf, unf;
    logic         chk_dout;
    logic [W-1:0] dout;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic clr, input logic enq, input logic deq, input logic [W-1:0] din);
    @(negedge CLK);
    CLR = clr; bus.ENQ = enq; bus.DEQ = deq; bus.D_IN = din;
    @(posedge CLK);
    #1;
    CLR = 1'b0; bus.ENQ = 1'b0; bus.DEQ = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, W'(bus.COUNT), 0);
    chk({tag, "_hwm"}, W'(bus.HWM), 0);
    chk({tag, "_full_n"}, W'(bus.FULL_N), 1);
    chk({tag, "_empty_n"}, W'(bus.EMPTY_N), 0);
    chk({tag, "_ae"}, W'(bus.ALMOST_EMPTY), 1);
    chk({tag, "_af"}, W'(bus.ALMOST_FULL), 0);
    chk({tag, "_ovf"}, W'(bus.ERR_OVF), 0);
    chk({tag, "_unf"}, W'(bus.ERR_UNF), 0);
  endtask

  task automatic fill32();
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, W'(i));
  endtask

  initial begin
    //            clr  enq  deq  din     cnt fn en af ae hwm ovf unf cd dout
    vecs[0] = '{1'b1,1'b0,1'b0,W'(0),   6'd0,1,0,0,1,6'd0,0,0,0,W'(0)};
    vecs[1] = '{1'b0,1'b1,1'b1,W'(7),   6'd1,1,1,0,1,6'd1,0,1,1,W'(7)};
    vecs[2] = '{1'b0,1'b1,1'b0,W'(8),   6'd2,1,1,0,1,6'd2,0,1,1,W'(7)};
    vecs[3] = '{1'b0,1'b1,1'b0,W'(9),   6'd3,1,1,0,0,6'd3,0,1,1,W'(7)};
    vecs[4] = '{1'b0,1'b0,1'b1,W'(0),   6'd2,1,1,0,1,6'd3,0,1,1,W'(8)};
    vecs[5] = '{1'b0,1'b1,1'b1,W'(10),  6'd2,1,1,0,1,6'd3,0,1,1,W'(9)};
    vecs[6] = '{1'b1,1'b1,1'b0,W'(11),  6'd0,1,0,0,1,6'd0,0,0,0,W'(0)};
    vecs[7] = '{1'b0,1'b0,1'b1,W'(0),   6'd0,1,0,0,1,6'd0,0,1,0,W'(0)};
    vecs[8] = '{1'b0,1'b1,1'b0,W'(8'h55),6'd1,1,1,0,1,6'd1,0,1,1,W'(8'h55)};

    RST_N = 1'b0; CLR = 1'b0; bus.ENQ = 1'b0; bus.DEQ = 1'b0; bus.D_IN = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk_reset_state("reset");

    // Fill with flag tracking; first word falls through after edge 1.
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 1'b0, W'(i));
      chk("fill_count", W'(bus.COUNT), W'(i + 1));
      chk("fill_full_n", W'(bus.FULL_N), W'(i + 1 != 32));
      chk("fill_af", W'(bus.ALMOST_FULL), W'(i + 1 >= 28));
      chk("fill_ae", W'(bus.ALMOST_EMPTY), W'(i + 1 <= 2));
      chk("fill_dout", bus.D_OUT, W'(0));
    end
    chk("fill_hwm", W'(bus.HWM), 32);

    for (int i = 0; i < 32; i++) begin
      chk("drain_dout", bus.D_OUT, W'(i));
      step(1'b0, 1'b0, 1'b1, '0);
      chk("drain_count", W'(bus.COUNT), W'(31 - i));
      chk("drain_empty_n", W'(bus.EMPTY_N), W'(i != 31));
      chk("drain_ae", W'(bus.ALMOST_EMPTY), W'(31 - i <= 2));
    end
    chk("drain_ovf", W'(bus.ERR_OVF), 0);
    chk("drain_unf", W'(bus.ERR_UNF), 0);
    chk("drain_hwm", W'(bus.HWM), 32);

    // Pass-through while full.
    fill32();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b1, W'(100 + i));
      chk("pass_count", W'(bus.COUNT), 32);
      chk("pass_full_n", W'(bus.FULL_N), 0);
      chk("pass_ovf", W'(bus.ERR_OVF), 0);
    end
    for (int i = 0; i < 32; i++) begin
      chk("pass_drain", bus.D_OUT, (i < 27) ? W'(i + 5) : W'(100 + i - 27));
      step(1'b0, 1'b0, 1'b1, '0);
    end

    // Overflow drop, then underflow.
    fill32();
    step(1'b0, 1'b1, 1'b0, W'(16'hDEAD));
    chk("ovf_flag", W'(bus.ERR_OVF), 1);
    chk("ovf_count", W'(bus.COUNT), 32);
    for (int i = 0; i < 32; i++) begin
      chk("ovf_drain", bus.D_OUT, W'(i));
      step(1'b0, 1'b0, 1'b1, '0);
    end
    chk("ovf_unf_before", W'(bus.ERR_UNF), 0);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("unf_flag", W'(bus.ERR_UNF), 1);
    chk("unf_count", W'(bus.COUNT), 0);
    chk("unf_ovf_sticky", W'(bus.ERR_OVF), 1);

    for (int v = 0; v < 9; v++) begin
      step(vecs[v].clr, vecs[v].enq, vecs[v].deq, vecs[v].din);
      chk($sformatf("vec%0d_count", v), W'(bus.COUNT), W'(vecs[v].count));
      chk($sformatf("vec%0d_full_n", v), W'(bus.FULL_N), W'(vecs[v].full_n));
      chk($sformatf("vec%0d_empty_n", v), W'(bus.EMPTY_N), W'(vecs[v].empty_n));
      chk($sformatf("vec%0d_af", v), W'(bus.ALMOST_FULL), W'(vecs[v].af));
      chk($sformatf("vec%0d_ae", v), W'(bus.ALMOST_EMPTY), W'(vecs[v].ae));
      chk($sformatf("vec%0d_hwm", v), W'(bus.HWM), W'(vecs[v].hwm));
      chk($sformatf("vec%0d_ovf", v), W'(bus.ERR_OVF), W'(vecs[v].ovf));
      chk($sformatf("vec%0d_unf", v), W'(bus.ERR_UNF), W'(vecs[v].unf));
      if (vecs[v].chk_dout) chk($sformatf("vec%0d_dout", v), bus.D_OUT, vecs[v].dout);
    end

    // COUNT=10 with ERR_OVF set, then CLR beats a concurrent ENQ.
    step(1'b1, 1'b0, 1'b0, '0);
    fill32();
    step(1'b0, 1'b1, 1'b0, W'(16'hBEEF));
    for (int i = 0; i < 22; i++) step(1'b0, 1'b0, 1'b1, '0);
    chk("pre_clr_count", W'(bus.COUNT), 10);
    chk("pre_clr_ovf", W'(bus.ERR_OVF), 1);
    chk("pre_clr_hwm", W'(bus.HWM), 32);
    chk("pre_clr_dout", bus.D_OUT, W'(22));
    step(1'b1, 1'b1, 1'b0, W'(1));
    chk_reset_state("clr");

    // Asynchronous reset mid-cycle, before any further edge.
    step(1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, W'(i));
    chk("pre_rst_count", W'(bus.COUNT), 3);
    chk("pre_rst_unf", W'(bus.ERR_UNF), 1);
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk_reset_state("async_rst");
    @(negedge CLK);
    RST_N = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
